// File: rtl/espi_frame_seq.sv
// Frame sequencer in front of the per-character SPI engine: buffers TX and RX characters,
// holds chip select low for a whole frame and issues one CHAR_GO per character.
module espi_frame_seq #(
  parameter int CHAR_NBITS = 32,
  parameter int FIFO_AW    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  S_TX_ONLY,
  input  logic [15:0]           S_FRAME_LEN,
  input  logic                  S_FRAME_START,
  output logic                  S_FRAME_BUSY,
  output logic                  S_FRAME_DONE,
  input  logic                  S_TX_WR,
  input  logic [CHAR_NBITS-1:0] S_TX_DATA,
  output logic                  S_TX_FULL,
  output logic [FIFO_AW:0]      S_TX_CNT,
  input  logic                  S_RX_RD,
  output logic [CHAR_NBITS-1:0] S_RX_DATA,
  output logic                  S_RX_EMPTY,
  output logic                  S_RX_OVF,
  output logic                  C_CHAR_GO,
  input  logic                  C_CHAR_DONE,
  output logic [CHAR_NBITS-1:0] C_WCHAR,
  input  logic [CHAR_NBITS-1:0] C_RCHAR,
  output logic                  S_SPI_CS_N,
  output logic [2:0]            S_DBG_STATE
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int CYC_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX + 1) : 1;

  localparam logic [FIFO_AW:0] PTR_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ONE    = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(CS_SETUP - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_GO    = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  state_t                  state;
  logic                    cs_n;
  logic                    busy;
  logic                    done;
  logic                    go;
  logic [CHAR_NBITS-1:0]   wchar;
  logic [15:0]             len_cnt;
  logic [CYC_W-1:0]        cyc_cnt;
  logic                    ovf;

  // ---------------- TX FIFO ----------------
  logic [CHAR_NBITS-1:0] tx_mem [DEPTH];
  logic [FIFO_AW:0]      tx_wp;
  logic [FIFO_AW:0]      tx_rp;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_push;
  logic                  tx_pop;

  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_push  = S_TX_WR && !tx_full;

  always_ff @(posedge S_SYSCLK) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= S_TX_DATA;
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [CHAR_NBITS-1:0] rx_mem [DEPTH];
  logic [FIFO_AW:0]      rx_wp;
  logic [FIFO_AW:0]      rx_rp;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_push_req;
  logic                  rx_push;
  logic                  rx_pop;

  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                    (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_push  = rx_push_req && !rx_full;
  assign rx_pop   = S_RX_RD && !rx_empty;

  always_ff @(posedge S_SYSCLK) begin
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= C_RCHAR;
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
    end
  end

  // ---------------- frame FSM ----------------
  // Engine handshake: C_CHAR_GO is a one-cycle request carrying C_WCHAR, which stays
  // stable until the engine answers with a one-cycle C_CHAR_DONE carrying C_RCHAR.
  // Only one character is ever outstanding, and DONE is honoured only in WAIT.
  logic wait_done;
  logic load_ok;

  assign wait_done   = (state == ST_WAIT) && S_ENABLE && C_CHAR_DONE;
  assign rx_push_req = wait_done && !S_TX_ONLY;
  // A character is only launched when its reply is guaranteed a slot in the RX FIFO.
  assign load_ok     = (state == ST_LOAD) && S_ENABLE && !tx_empty &&
                       (S_TX_ONLY || !rx_full);
  assign tx_pop      = load_ok;

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      state   <= ST_IDLE;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      go      <= 1'b0;
      wchar   <= '0;
      len_cnt <= '0;
      cyc_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      go   <= 1'b0;
      if (rx_push_req && rx_full) ovf <= 1'b1;

      if (state != ST_IDLE && !S_ENABLE) begin
        state <= ST_IDLE;
        cs_n  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (S_FRAME_START && S_ENABLE) begin
              if (S_FRAME_LEN != 16'd0) begin
                len_cnt <= S_FRAME_LEN;
                ovf     <= 1'b0;
                cs_n    <= 1'b0;
                busy    <= 1'b1;
                cyc_cnt <= '0;
                state   <= ST_SETUP;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_SETUP: begin
            if (cyc_cnt == SETUP_LAST) begin
              cyc_cnt <= '0;
              state   <= ST_LOAD;
            end else begin
              cyc_cnt <= cyc_cnt + CYC_ONE;
            end
          end
          ST_LOAD: begin
            if (load_ok) begin
              wchar <= tx_mem[tx_rp[FIFO_AW-1:0]];
              go    <= 1'b1;
              state <= ST_GO;
            end
          end
          ST_GO: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (wait_done) begin
              len_cnt <= len_cnt - 16'd1;
              if (len_cnt == 16'd1) begin
                cyc_cnt <= '0;
                state   <= ST_HOLD;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
          ST_HOLD: begin
            if (cyc_cnt == HOLD_LAST) begin
              cs_n  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              cyc_cnt <= cyc_cnt + CYC_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign S_FRAME_BUSY = busy;
  assign S_FRAME_DONE = done;
  assign S_TX_FULL    = tx_full;
  assign S_TX_CNT     = tx_wp - tx_rp;
  assign S_RX_DATA    = rx_mem[rx_rp[FIFO_AW-1:0]];
  assign S_RX_EMPTY   = rx_empty;
  assign S_RX_OVF     = ovf;
  assign C_CHAR_GO    = go;
  assign C_WCHAR      = wchar;
  assign S_SPI_CS_N   = cs_n;
  assign S_DBG_STATE  = state;

endmodule

// File: tb/tb_espi_frame_seq.sv
// Bench for espi_frame_seq: loopback engine model, queue-based FIFO scoreboard checked
// every cycle, and directed frame scenarios with hand-computed timing and data.
module tb_espi_frame_seq;
  localparam int W        = 32;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int ENG_LAT  = 3;

  logic          S_SYSCLK = 1'b0;
  logic          S_RESETN;
  logic          S_ENABLE;
  logic          S_TX_ONLY;
  logic [15:0]   S_FRAME_LEN;
  logic          S_FRAME_START;
  logic          S_FRAME_BUSY;
  logic          S_FRAME_DONE;
  logic          S_TX_WR;
  logic [W-1:0]  S_TX_DATA;
  logic          S_TX_FULL;
  logic [AW:0]   S_TX_CNT;
  logic          S_RX_RD;
  logic [W-1:0]  S_RX_DATA;
  logic          S_RX_EMPTY;
  logic          S_RX_OVF;
  logic          C_CHAR_GO;
  logic          C_CHAR_DONE;
  logic [W-1:0]  C_WCHAR;
  logic [W-1:0]  C_RCHAR;
  logic          S_SPI_CS_N;
  logic [2:0]    dbg_state;

  // ---------------- clock ----------------
  always #5 S_SYSCLK = ~S_SYSCLK;

  espi_frame_seq #(
    .CHAR_NBITS(W), .FIFO_AW(AW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .S_SYSCLK(S_SYSCLK), .S_RESETN(S_RESETN), .S_ENABLE(S_ENABLE), .S_TX_ONLY(S_TX_ONLY),
    .S_FRAME_LEN(S_FRAME_LEN), .S_FRAME_START(S_FRAME_START),
    .S_FRAME_BUSY(S_FRAME_BUSY), .S_FRAME_DONE(S_FRAME_DONE),
    .S_TX_WR(S_TX_WR), .S_TX_DATA(S_TX_DATA), .S_TX_FULL(S_TX_FULL), .S_TX_CNT(S_TX_CNT),
    .S_RX_RD(S_RX_RD), .S_RX_DATA(S_RX_DATA), .S_RX_EMPTY(S_RX_EMPTY), .S_RX_OVF(S_RX_OVF),
    .C_CHAR_GO(C_CHAR_GO), .C_CHAR_DONE(C_CHAR_DONE), .C_WCHAR(C_WCHAR), .C_RCHAR(C_RCHAR),
    .S_SPI_CS_N(S_SPI_CS_N), .S_DBG_STATE(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, n_go = 0, n_done = 0, n_cs_fall = 0;
  int cs_fall_cyc = -1, first_go_cyc = -1, last_cdone_cyc = -1;
  int cs_rise_cyc = -1, done_cyc = -1, last_gap = -1;
  logic cs_prev = 1'b1;
  int eng_cnt = 0;
  logic [W-1:0] eng_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- loopback engine ----------------
  initial begin
    C_CHAR_DONE = 1'b0;
    C_RCHAR     = '0;
    forever begin
      @(posedge S_SYSCLK); #1;
      C_CHAR_DONE = 1'b0;
      if (!S_RESETN) begin
        eng_cnt = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          C_CHAR_DONE = 1'b1;
          C_RCHAR     = eng_data;
        end
      end else if (C_CHAR_GO) begin
        eng_cnt  = ENG_LAT;
        eng_data = C_WCHAR;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int tx_sz, rx_sz;
  always @(negedge S_SYSCLK) begin
    if (!S_RESETN) begin
      tx_q.delete();
      exp_q.delete();
      cs_prev = 1'b1;
    end else begin
      cyc++;
      if (!S_SPI_CS_N && cs_prev) begin
        cs_fall_cyc  = cyc;
        first_go_cyc = -1;
        n_cs_fall++;
      end
      if (S_SPI_CS_N && !cs_prev) cs_rise_cyc = cyc;
      cs_prev = S_SPI_CS_N;

      if (C_CHAR_GO) begin
        n_go++;
        if (first_go_cyc < 0) first_go_cyc = cyc;
        if (last_cdone_cyc >= 0) last_gap = cyc - last_cdone_cyc;
        check("cs_low_at_go", S_SPI_CS_N, 1'b0);
        check("go_has_tx_char", tx_q.size() > 0, 1'b1);
        if (tx_q.size() > 0) check("wchar", C_WCHAR, tx_q.pop_front());
      end
      if (S_FRAME_DONE) begin
        n_done++;
        done_cyc = cyc;
        check("cs_high_at_done", S_SPI_CS_N, 1'b1);
        check("busy_low_at_done", S_FRAME_BUSY, 1'b0);
      end
      if (C_CHAR_DONE && S_ENABLE) check("wchar_stable", C_WCHAR, eng_data);

      check("tx_cnt", S_TX_CNT, tx_q.size());
      check("tx_full", S_TX_FULL, tx_q.size() == DEPTH);
      check("rx_empty", S_RX_EMPTY, exp_q.size() == 0);
      if (exp_q.size() > 0) check("rx_head", S_RX_DATA, exp_q[0]);
      check("rx_ovf", S_RX_OVF, 1'b0);

      // apply the inputs the DUT samples on the coming edge
      tx_sz = tx_q.size();
      rx_sz = exp_q.size();
      if (S_RX_RD && rx_sz > 0) void'(exp_q.pop_front());
      if (C_CHAR_DONE) begin
        last_cdone_cyc = cyc;
        if (S_ENABLE && !S_TX_ONLY && rx_sz < DEPTH) exp_q.push_back(C_RCHAR);
      end
      if (S_TX_WR && tx_sz < DEPTH) tx_q.push_back(S_TX_DATA);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge S_SYSCLK); #1;
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    S_TX_WR = 1'b1; S_TX_DATA = d;
    tick();
    S_TX_WR = 1'b0;
  endtask

  task automatic pop_rx();
    S_RX_RD = 1'b1;
    tick();
    S_RX_RD = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] len);
    S_FRAME_LEN = len; S_FRAME_START = 1'b1;
    tick();
    S_FRAME_START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    int d0;
    n = 0; d0 = n_done;
    while (n_done == d0 && n < budget) begin tick(); n++; end
    check({name, "_done_in_time"}, n_done != d0, 1'b1);
  endtask

  task automatic wait_gos(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n_go < target && n < budget) begin tick(); n++; end
    check({name, "_go_in_time"}, n_go >= target, 1'b1);
  endtask

  task automatic expect_rx(input string name, input logic [W-1:0] d);
    check(name, S_RX_DATA, d);
    pop_rx();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int g0, d0, k, guard, nrx;
  initial begin
    S_RESETN = 1'b0; S_ENABLE = 1'b0; S_TX_ONLY = 1'b0; S_FRAME_LEN = '0;
    S_FRAME_START = 1'b0; S_TX_WR = 1'b0; S_TX_DATA = '0; S_RX_RD = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", S_SPI_CS_N, 1'b1);
    check("rst_tx_cnt", S_TX_CNT, 0);
    check("rst_tx_full", S_TX_FULL, 1'b0);
    check("rst_rx_empty", S_RX_EMPTY, 1'b1);
    check("rst_go", C_CHAR_GO, 1'b0);
    check("rst_busy", S_FRAME_BUSY, 1'b0);
    check("rst_done", S_FRAME_DONE, 1'b0);
    check("rst_wchar", C_WCHAR, 0);
    check("rst_ovf", S_RX_OVF, 1'b0);
    S_RESETN = 1'b1; S_ENABLE = 1'b1;
    tick();

    // zero-length start: DONE next cycle, CS untouched
    start_frame(16'd0);
    check("len0_done", S_FRAME_DONE, 1'b1);
    check("len0_cs_n", S_SPI_CS_N, 1'b1);
    check("len0_busy", S_FRAME_BUSY, 1'b0);
    tick();
    check("len0_done_pulse", S_FRAME_DONE, 1'b0);

    // 1) three-character loopback frame with CS setup/hold timing
    push_tx(32'hA5); push_tx(32'h5A); push_tx(32'h3C);
    g0 = n_go; d0 = n_done; k = n_cs_fall;
    start_frame(16'd3);
    check("t1_busy", S_FRAME_BUSY, 1'b1);
    wait_done("t1", 200);
    repeat (3) tick();
    check("t1_go_count", n_go - g0, 3);
    check("t1_done_count", n_done - d0, 1);
    check("t1_single_cs", n_cs_fall - k, 1);
    check("t1_cs_to_go", first_go_cyc - cs_fall_cyc, CS_SETUP + 1);
    check("t1_done_to_cs", cs_rise_cyc - last_cdone_cyc, CS_HOLD + 1);
    check("t1_done_with_cs", done_cyc, cs_rise_cyc);
    check("t1_done_to_go", last_gap, 2);
    expect_rx("t1_rx0", 32'hA5);
    expect_rx("t1_rx1", 32'h5A);
    expect_rx("t1_rx2", 32'h3C);
    check("t1_rx_drained", S_RX_EMPTY, 1'b1);

    // 2) underfed frame stalls in LOAD with CS low, completes after refill
    g0 = n_go; d0 = n_done;
    push_tx(32'h11); push_tx(32'h22);
    start_frame(16'd4);
    repeat (60) tick();
    check("t2_stall_go", n_go - g0, 2);
    check("t2_stall_cs", S_SPI_CS_N, 1'b0);
    check("t2_stall_busy", S_FRAME_BUSY, 1'b1);
    check("t2_stall_nodone", n_done - d0, 0);
    push_tx(32'h33); push_tx(32'h44);
    wait_done("t2", 200);
    check("t2_go_count", n_go - g0, 4);
    expect_rx("t2_rx0", 32'h11);
    expect_rx("t2_rx1", 32'h22);
    expect_rx("t2_rx2", 32'h33);
    expect_rx("t2_rx3", 32'h44);

    // 3) TX-only frame longer than the FIFO, refilled on the fly
    S_TX_ONLY = 1'b1;
    g0 = n_go; d0 = n_done;
    fork
      start_frame(16'd20);
      begin
        k = 0; guard = 0;
        while (k < 20 && guard < 2000) begin
          if (!S_TX_FULL) begin
            S_TX_WR = 1'b1; S_TX_DATA = 32'h1000 + k; k++;
          end else begin
            S_TX_WR = 1'b0;
          end
          tick(); guard++;
        end
        S_TX_WR = 1'b0;
      end
    join
    wait_done("t3", 1000);
    check("t3_go_count", n_go - g0, 20);
    check("t3_rx_empty", S_RX_EMPTY, 1'b1);
    check("t3_ovf", S_RX_OVF, 1'b0);
    S_TX_ONLY = 1'b0;
    tick();

    // 4) full RX FIFO blocks launches; each pop frees exactly one character
    for (int i = 0; i < 16; i++) push_tx(32'h2000 + i);
    start_frame(16'd16);
    wait_done("t4_fill", 500);
    push_tx(32'h3000); push_tx(32'h3001);
    g0 = n_go;
    start_frame(16'd2);
    repeat (40) tick();
    check("t4_blocked_go", n_go - g0, 0);
    check("t4_blocked_cs", S_SPI_CS_N, 1'b0);
    check("t4_blocked_tx", S_TX_CNT, 2);
    expect_rx("t4_head", 32'h2000);
    repeat (40) tick();
    check("t4_one_go", n_go - g0, 1);
    check("t4_one_tx", S_TX_CNT, 1);
    check("t4_busy", S_FRAME_BUSY, 1'b1);
    pop_rx();
    wait_done("t4", 200);
    check("t4_go_count", n_go - g0, 2);
    nrx = exp_q.size();
    check("t4_rx_level", nrx, 16);
    repeat (nrx) pop_rx();
    check("t4_rx_drained", S_RX_EMPTY, 1'b1);

    // 5) abort during WAIT of character 2 of 5
    for (int i = 0; i < 5; i++) push_tx(32'h4000 + i);
    g0 = n_go; d0 = n_done;
    start_frame(16'd5);
    wait_gos("t5", g0 + 2, 200);
    check("t5_cs_before_abort", S_SPI_CS_N, 1'b0);
    S_ENABLE = 1'b0;
    tick();
    check("t5_abort_cs", S_SPI_CS_N, 1'b1);
    check("t5_abort_busy", S_FRAME_BUSY, 1'b0);
    check("t5_abort_done", S_FRAME_DONE, 1'b0);
    repeat (10) tick();
    check("t5_no_done", n_done - d0, 0);
    check("t5_tx_left", S_TX_CNT, 3);
    check("t5_go_count", n_go - g0, 2);
    S_ENABLE = 1'b1;
    expect_rx("t5_rx0", 32'h4000);
    check("t5_rx_empty", S_RX_EMPTY, 1'b1);

    // 6) asynchronous reset mid-frame
    g0 = n_go;
    start_frame(16'd3);
    wait_gos("t6", g0 + 1, 200);
    #2 S_RESETN = 1'b0;
    #1;
    check("t6_cs_n", S_SPI_CS_N, 1'b1);
    check("t6_tx_cnt", S_TX_CNT, 0);
    check("t6_rx_empty", S_RX_EMPTY, 1'b1);
    check("t6_go", C_CHAR_GO, 1'b0);
    check("t6_busy", S_FRAME_BUSY, 1'b0);
    repeat (2) @(posedge S_SYSCLK);
    #3 S_RESETN = 1'b1;
    repeat (5) tick();
    check("t6_idle_cs", S_SPI_CS_N, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
